// File: rtl/mult_pkg.sv
// Shared types and helpers for the pipelined multiplier.
//  - mult_op_t : one multiply request (operands, signed mode, tag) at the default widths.
//  - half_of() : half of an operand width, used to split operands into halves.
//  - abs_w()   : two's-complement magnitude of a sign-extended value.
// The operand width is a module parameter, so abs_w() works on a fixed wide
// vector: callers sign-extend to MAX_W bits and keep the low WIDTH bits of the
// result. The magnitude of the most-negative WIDTH-bit value is 2^(WIDTH-1),
// which still fits in WIDTH unsigned bits.
package mult_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_TAG_W = 4;
  localparam int MAX_W     = 128;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic                 is_signed;
    logic [DEF_TAG_W-1:0] tag;
  } mult_op_t;

  function automatic int half_of(input int w);
    return w / 2;
  endfunction

  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v);
    return v[MAX_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mult_pp_array.sv
// Partial-product stage of the pipelined multiplier.
// Splits two WIDTH-bit unsigned magnitudes into WIDTH/2-bit halves and
// registers the four half-by-half products (each fits in WIDTH bits).
// Ports:
//  clk, rst_n   clock, asynchronous active-low reset (products clear to 0)
//  en           advance enable; when 0 all four registers hold
//  a, b         unsigned magnitudes from the accept stage
//  ll, lh       aL*bL, aL*bH
//  hl, hh       aH*bL, aH*bH
module mult_pp_array
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] ll,
  output logic [WIDTH-1:0] lh,
  output logic [WIDTH-1:0] hl,
  output logic [WIDTH-1:0] hh
);

  localparam int HALF = half_of(WIDTH);

  // Halves zero-extended to WIDTH so each product is computed at full width.
  logic [WIDTH-1:0] a_lo, a_hi, b_lo, b_hi;

  assign a_lo = {{HALF{1'b0}}, a[HALF-1:0]};
  assign a_hi = {{HALF{1'b0}}, a[WIDTH-1:HALF]};
  assign b_lo = {{HALF{1'b0}}, b[HALF-1:0]};
  assign b_hi = {{HALF{1'b0}}, b[WIDTH-1:HALF]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ll <= '0;
      lh <= '0;
      hl <= '0;
      hh <= '0;
    end else if (en) begin
      ll <= a_lo * b_lo;
      lh <= a_lo * b_hi;
      hl <= a_hi * b_lo;
      hh <= a_hi * b_hi;
    end
  end

endmodule

// File: rtl/multiplier_pipelined_hs.sv
// Three-stage pipelined WIDTH x WIDTH integer multiplier with valid/ready flow
// control, per-operation signed/unsigned mode and an opaque tag carried with
// each operation.
//  S1 (accept): sign of the result and operand magnitudes.
//  S2 (mult_pp_array): four half-width partial products.
//  S3 (output): partial products summed at 2*WIDTH bits, sign applied.
// Ports:
//  clk, rst_n            clock, asynchronous active-low reset
//  in_valid / in_ready   operand handshake from the issue stage
//  in_a, in_b            multiplicand / multiplier
//  in_signed             1: two's-complement operation, 0: unsigned
//  in_tag                tag returned with the product
//  out_valid / out_ready product handshake to writeback
//  out_r                 2*WIDTH-bit product
//  out_tag               tag of the product on out_r
// WIDTH must be even and at least 4.
//
// Handshake: a transfer happens on a side in any cycle where its valid and
// ready are both 1. The producer holds in_* stable while in_ready=0; this block
// holds out_r/out_tag stable while out_valid=1 and out_ready=0. The whole pipe
// moves together on adv = !out_valid || out_ready, and in_ready is adv itself,
// so accept and drain in the same cycle sustain one operation per clock.
module multiplier_pipelined_hs
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_r,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int HALF = half_of(WIDTH);

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1: sign and magnitudes ----------------
  logic [MAX_W-1:0] ext_a, ext_b;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             neg_in;

  assign ext_a  = MAX_W'(signed'(in_a));
  assign ext_b  = MAX_W'(signed'(in_b));
  assign a_mag  = in_signed ? WIDTH'(abs_w(ext_a)) : in_a;
  assign b_mag  = in_signed ? WIDTH'(abs_w(ext_b)) : in_b;
  assign neg_in = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);

  logic             s1_valid, s1_neg;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [TAG_W-1:0] s1_tag;

  // Bubbles are loaded too: the valid bit alone marks the stage as empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_neg   <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_neg   <= neg_in;
      s1_a     <= a_mag;
      s1_b     <= b_mag;
      s1_tag   <= in_tag;
    end
  end

  // ---------------- S2: partial products ----------------
  logic [WIDTH-1:0] pp_ll, pp_lh, pp_hl, pp_hh;
  logic             s2_valid, s2_neg;
  logic [TAG_W-1:0] s2_tag;

  mult_pp_array #(
    .WIDTH (WIDTH)
  ) u_pp (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .a     (s1_a),
    .b     (s1_b),
    .ll    (pp_ll),
    .lh    (pp_lh),
    .hl    (pp_hl),
    .hh    (pp_hh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_neg   <= 1'b0;
      s2_tag   <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_neg   <= s1_neg;
      s2_tag   <= s1_tag;
    end
  end

  // ---------------- S3: sum and sign ----------------
  // The unsigned magnitude product is below 2^(2*WIDTH), and its negation
  // is at least -2^(2*WIDTH-2), so neither mode can overflow.
  logic [2*WIDTH-1:0] mag_prod, prod;

  always_comb begin
    mag_prod = {pp_hh, {WIDTH{1'b0}}}
             + {{HALF{1'b0}}, pp_lh, {HALF{1'b0}}}
             + {{HALF{1'b0}}, pp_hl, {HALF{1'b0}}}
             + {{WIDTH{1'b0}}, pp_ll};
    prod     = s2_neg ? (~mag_prod + 1'b1) : mag_prod;
  end

  // Data registers only load real results, so a bubble leaves the last
  // product visible (out_valid=0) instead of partial-sum noise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_r   <= prod;
        out_tag <= s2_tag;
      end
    end
  end

endmodule
